// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared width and bus-owner encodings for the memory port-2
//               arbiter and its port multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    // Bus owner. The same encoding is the arbiter state and the debug output.
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_DMA   = 2'd2,
        OWN_YIELD = 2'd3
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_bus_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : bus_port_mux
// Description : Combinational select of the CPU or DMA request onto memory
//               data port 2.
//   sel            : OWN_CPU/OWN_YIELD -> CPU side, OWN_DMA -> DMA side,
//                    OWN_IDLE -> port idle (all zero)
//   cpu_*          : CPU data-side request
//   dma_*          : DMA memory-to-external-device write request
//   mem_*          : memory port 2 request
// Revision    : 1.0 - initial release
// ============================================================================
module bus_port_mux
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = mem_bus_arbiter_pkg::WORD_SIZE
) (
    input  owner_t               sel,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_write_data,
    input  logic                 dma_mtoe,
    input  logic [WORD_SIZE-1:0] dma_address,
    input  logic [WORD_SIZE-1:0] dma_write_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_write_data
);

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (sel)
            OWN_CPU, OWN_YIELD: begin
                // Read and write together resolve to a write.
                mem_read       = cpu_read & ~cpu_write;
                mem_write      = cpu_write;
                mem_address    = cpu_address;
                mem_write_data = cpu_write_data;
            end
            OWN_DMA: begin
                mem_write      = dma_mtoe;
                mem_address    = dma_address;
                mem_write_data = dma_write_data;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Arbitrates memory data port 2 between CPU data accesses and
//               DMA writes, with BR/BG handshake and bounded cycle stealing.
//   clk, reset_n        : clock, asynchronous active-low reset
//   cpu_* / cpu_stall   : CPU data request and stall back to the CPU
//   dma_br / dma_bg     : DMA bus request / grant
//   dma_mtoe, dma_*     : DMA write request, burst-end pulse
//   mem_done, mem_*     : memory port 2 completion and request
//   owner, steal_count  : debug owner state, saturating forced-yield count
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = mem_bus_arbiter_pkg::WORD_SIZE,
    parameter int MAX_BURSTS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_write_data,
    output logic                 cpu_stall,
    input  logic                 dma_br,
    output logic                 dma_bg,
    input  logic                 dma_mtoe,
    input  logic [WORD_SIZE-1:0] dma_address,
    input  logic [WORD_SIZE-1:0] dma_write_data,
    input  logic                 dma_burst_done,
    input  logic                 mem_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_write_data,
    output logic [1:0]           owner,
    output logic [WORD_SIZE-1:0] steal_count
);

    localparam logic [3:0] c_max_bursts = 4'(MAX_BURSTS);

    owner_t               r_state;
    logic                 r_dma_bg;
    logic [3:0]           r_burst_cnt;
    logic [WORD_SIZE-1:0] r_steal_count;

    logic                 w_cpu_req;
    logic [3:0]           w_burst_inc;
    owner_t               w_port_sel;

    assign w_cpu_req   = cpu_read | cpu_write;
    assign w_burst_inc = r_burst_cnt + 4'd1;

    // dma_bg is updated together with the state so it is a clean flop output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= OWN_IDLE;
            r_dma_bg      <= 1'b0;
            r_burst_cnt   <= 4'd0;
            r_steal_count <= '0;
        end else begin
            case (r_state)
                OWN_IDLE: begin
                    if (dma_br) begin
                        r_state  <= OWN_DMA;
                        r_dma_bg <= 1'b1;
                    end else if (w_cpu_req && !mem_done) begin
                        // A single-cycle access already completed stays IDLE.
                        r_state <= OWN_CPU;
                    end
                end
                OWN_CPU: begin
                    if (mem_done) begin
                        r_state  <= dma_br ? OWN_DMA : OWN_IDLE;
                        r_dma_bg <= dma_br;
                    end
                end
                OWN_DMA: begin
                    if (!dma_br) begin
                        // Release wins over a coincident forced yield.
                        r_state     <= OWN_IDLE;
                        r_dma_bg    <= 1'b0;
                        r_burst_cnt <= 4'd0;
                    end else if (dma_burst_done) begin
                        if (!w_cpu_req) begin
                            r_burst_cnt <= 4'd0;
                        end else if (w_burst_inc >= c_max_bursts) begin
                            r_state     <= OWN_YIELD;
                            r_dma_bg    <= 1'b0;
                            r_burst_cnt <= 4'd0;
                            if (r_steal_count != '1) begin
                                r_steal_count <= r_steal_count + 1'b1;
                            end
                        end else begin
                            r_burst_cnt <= w_burst_inc;
                        end
                    end
                end
                OWN_YIELD: begin
                    // Leave once the forced CPU access finishes or is withdrawn.
                    if (mem_done || !w_cpu_req) begin
                        r_state  <= dma_br ? OWN_DMA : OWN_IDLE;
                        r_dma_bg <= dma_br;
                    end
                end
                default: begin
                    r_state  <= OWN_IDLE;
                    r_dma_bg <= 1'b0;
                end
            endcase
        end
    end

    // In IDLE an uncontested CPU request goes straight to memory.
    always_comb begin
        w_port_sel = OWN_IDLE;
        case (r_state)
            OWN_IDLE:           w_port_sel = (!dma_br && w_cpu_req) ? OWN_CPU : OWN_IDLE;
            OWN_CPU, OWN_YIELD: w_port_sel = OWN_CPU;
            OWN_DMA:            w_port_sel = OWN_DMA;
            default:            w_port_sel = OWN_IDLE;
        endcase
        if (!reset_n) begin
            w_port_sel = OWN_IDLE;
        end
    end

    assign cpu_stall = reset_n & w_cpu_req &
                       ((r_state == OWN_DMA) || (r_state == OWN_IDLE && dma_br));

    bus_port_mux #(
        .WORD_SIZE (WORD_SIZE)
    ) u_bus_port_mux (
        .sel            (w_port_sel),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .dma_mtoe       (dma_mtoe),
        .dma_address    (dma_address),
        .dma_write_data (dma_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data)
    );

    assign dma_bg      = r_dma_bg;
    assign owner       = r_state;
    assign steal_count = r_steal_count;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns memory data port 2, which is shared between the CPU data-side access (read_m2/write_m2) and the DMA engine's memory-to-external-device writes.
- Implements the BR/BG handshake toward the DMA engine and stalls the CPU while the DMA engine owns the bus.
- Implements bounded cycle stealing: after a set number of DMA bursts, a waiting CPU access is forced through.
- Sits between the cpu, dma and Memory instances. It replaces the ad-hoc address/data/write muxing in the top level.

Parameters:
- WORD_SIZE, 16, address/data width.
- MAX_BURSTS, 2, number of DMA bursts completed while the CPU waits before the arbiter forces a yield (range 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- cpu_read  in  1  CPU data read request, held until mem_done
- cpu_write  in  1  CPU data write request, held until mem_done
- cpu_address  in  WORD_SIZE  CPU data address
- cpu_write_data  in  WORD_SIZE  CPU store data
- cpu_stall  out  1  CPU must hold its request; access not granted
- dma_br  in  1  DMA bus request, level
- dma_bg  out  1  bus grant to DMA, level
- dma_mtoe  in  1  DMA is driving a memory write this cycle
- dma_address  in  WORD_SIZE  DMA memory address
- dma_write_data  in  WORD_SIZE  DMA write data
- dma_burst_done  in  1  one-cycle pulse at the end of each DMA burst
- mem_done  in  1  memory access complete (mem_signal)
- mem_read  out  1  to Memory port 2
- mem_write  out  1  to Memory port 2
- mem_address  out  WORD_SIZE  to Memory port 2
- mem_write_data  out  WORD_SIZE  to Memory port 2
- owner  out  2  0 = IDLE, 1 = CPU, 2 = DMA, 3 = YIELD (debug)
- steal_count  out  WORD_SIZE  number of forced yields since reset, saturating

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE; dma_bg = 0; cpu_stall = 0; mem_read = mem_write = 0; address and data outputs = 0.
  - burst_cnt = 0; steal_count = 0. Reset mid-transfer drops dma_bg immediately.
- The state register is clocked. The port mux and cpu_stall are combinational from state and inputs. cpu_req = cpu_read | cpu_write.
- IDLE:
  - dma_br = 1: next state DMA. cpu_stall = cpu_req. Memory outputs are idle. DMA wins ties.
  - Else if cpu_req: CPU request passes to memory in the same cycle (zero added latency). cpu_stall = 0. Next state CPU, unless mem_done is already 1, in which case stay IDLE.
- CPU:
  - Memory outputs follow the CPU inputs.
  - On mem_done: next state DMA if dma_br = 1, else IDLE. An in-flight CPU access is never preempted.
- DMA:
  - dma_bg = 1. mem_write = dma_mtoe; mem_read = 0. Address and data follow the DMA inputs. cpu_stall = cpu_req.
  - On dma_burst_done with cpu_req = 1: burst_cnt increments.
  - If the incremented burst_cnt reaches MAX_BURSTS: next state YIELD, burst_cnt cleared, steal_count increments (saturates at 16'hFFFF).
  - On dma_burst_done with cpu_req = 0: burst_cnt cleared.
  - dma_br = 0: next state IDLE, burst_cnt cleared. Takes precedence over the yield transition in the same cycle.
- YIELD:
  - dma_bg = 0. The DMA engine pauses with br still held and must not assert mtoe.
  - CPU access is granted as in CPU state.
  - On mem_done: next state DMA if dma_br = 1, else IDLE.
  - If cpu_req drops without mem_done: return to DMA (or IDLE if dma_br = 0).
- dma_bg rises no earlier than one cycle after dma_br and never while a CPU access is in flight.
- dma_mtoe while dma_bg = 0 is a protocol error. It is ignored: mem_write is not driven from DMA.
- cpu_read and cpu_write both asserted: treated as a write; mem_read = 0.

Decomposition:
- Shared package (defines include): WORD_SIZE and state encodings OWN_IDLE/OWN_CPU/OWN_DMA/OWN_YIELD (2-bit).
- One natural sub-module: bus_port_mux, a combinational select of the CPU or DMA request onto the memory port given owner.
- The FSM, burst counter and steal counter stay in mem_bus_arbiter.

Test Plan:
- CPU read at 16'h0040, no br, mem_done after 3 cycles: mem_read = 1 with address 0x0040 in the same cycle; cpu_stall = 0 throughout; owner returns to 0.
- br asserted during that CPU read: dma_bg stays 0 until the cycle after mem_done, then dma_bg = 1 and owner = 2.
- br and cpu_read rise in the same cycle in IDLE: dma_bg = 1 next cycle; cpu_stall = 1 until br drops.
- DMA owns the bus, CPU waiting, two dma_burst_done pulses (MAX_BURSTS = 2):
  - dma_bg drops after the 2nd pulse; owner = 3; CPU access completes; steal_count = 1.
  - dma_bg returns to 1 after mem_done.
- DMA owns the bus, dma_mtoe = 1, address 0x01F0, data 0xABCD: mem_write = 1 with that address and data. Drop br: owner = 0, dma_bg = 0 next cycle.
- reset_n pulled low mid-DMA: dma_bg, mem_write and steal_count are 0 asynchronously, before the next clk edge.
